// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: capture FSM encoding and rx word field layout,
// reused by the RX capture path and the TX side.
package uart_rx_fifo_pkg;

  localparam int READY_BIT = 15;
  localparam int BYTE_HI   = 7;
  localparam int BYTE_LO   = 0;

  localparam logic [1:0] ST_ARM        = 2'd0;
  localparam logic [1:0] ST_WAIT_READY = 2'd1;
  localparam logic [1:0] ST_WAIT_BYTE  = 2'd2;
  localparam logic [1:0] ST_PUSH       = 2'd3;

  function automatic logic [BYTE_HI-BYTE_LO:0] rx_byte(input logic [15:0] w);
    return w[BYTE_HI:BYTE_LO];
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; flags derive from level.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_pop, wr_ok;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same edge, so a push into a full FIFO still lands.
  assign wr_ok   = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok)  wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UartRX capture FSM (clear / wait ready / wait byte / push) feeding a
// show-ahead byte FIFO with sticky overflow.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ARM_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            rx_word,
  output logic                   rx_clear,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   ovf_clr
);
  localparam int TW = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;

  logic [1:0]    state;
  logic [TW-1:0] cnt;
  logic [7:0]    cap;
  logic          push, drop;
  logic          rx_unused;

  assign rx_unused = ^rx_word[14:8];

  // State resets to ARM, but the strobe must stay low while reset is held.
  assign rx_clear = rst_n && (state == ST_ARM);
  assign push     = (state == ST_PUSH);
  // full implies non-empty, so any rd_en this edge frees a slot.
  assign drop     = push && full && !rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ARM;
      cnt   <= '0;
      cap   <= '0;
    end else begin
      case (state)
        ST_ARM: begin
          state <= ST_WAIT_READY;
          cnt   <= '0;
        end
        ST_WAIT_READY: begin
          if (rx_word[READY_BIT])             state <= ST_WAIT_BYTE;
          else if (cnt == TW'(ARM_TIMEOUT-1)) state <= ST_ARM;
          else                                cnt   <= cnt + 1'b1;
        end
        ST_WAIT_BYTE: begin
          if (!rx_word[READY_BIT]) begin
            cap   <= rx_byte(rx_word);
            state <= ST_PUSH;
          end
        end
        ST_PUSH: state <= ST_ARM;
        default: state <= ST_ARM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (cap),
    .pop     (rd_en),
    .rd_data (rd_data),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: a bench-side UartRX driver feeds bytes, a queue model
// predicts FIFO contents/flags, and a negedge monitor compares.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int T     = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] rx_word = 16'h0000;
  logic        rx_clear;
  logic        rd_en, ovf_clr;
  logic [7:0]  rd_data;
  logic        empty, full, overflow;
  logic [4:0]  level;

  logic rd_dir = 1'b0, rd_rand = 1'b0, ovf_dir = 1'b0, ovf_rand = 1'b0;
  bit   cons_en = 1'b0, mon_en = 1'b0, cap_now = 1'b0;
  int   rd_pct = 40;

  assign rd_en   = cons_en ? rd_rand  : rd_dir;
  assign ovf_clr = cons_en ? ovf_rand : ovf_dir;

  int         checks = 0, errors = 0;
  int         mlevel = 0;
  bit         movf = 1'b0, push_pend = 1'b0;
  logic [7:0] pend_byte;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(.DEPTH(DEPTH), .ARM_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .rx_word(rx_word), .rx_clear(rx_clear),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
    .level(level), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a byte sampled by WAIT_BYTE lands one edge later,
  // after any pop on that edge; a full queue drops it and sets overflow.
  always @(posedge clk or negedge rst_n) begin
    bit pop_m, set_m;
    if (!rst_n) begin
      mlevel = 0; movf = 1'b0; push_pend = 1'b0; exp_q.delete();
    end else begin
      pop_m = rd_en && (mlevel > 0);
      set_m = 1'b0;
      if (pop_m) mlevel--;
      if (push_pend) begin
        if (mlevel < DEPTH) begin exp_q.push_back(pend_byte); mlevel++; end
        else begin movf = 1'b1; set_m = 1'b1; end
        push_pend = 1'b0;
      end
      if (ovf_clr && !set_m) movf = 1'b0;
      if (cap_now) begin push_pend = 1'b1; pend_byte = rx_word[7:0]; end
    end
  end

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("level", int'(level), mlevel);
      chk("overflow", int'(overflow), int'(movf));
      chk("empty", int'(empty), int'(mlevel == 0));
      chk("full", int'(full), int'(mlevel == DEPTH));
      if (rd_en && !empty) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_data: got %0h expected none (model queue empty)", rd_data);
        end else chk("rd_data", int'(rd_data), int'(exp_q.pop_front()));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    rd_rand  = ($urandom % 100) < rd_pct;
    ovf_rand = ($urandom % 100) < 3;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_clear(output bit ok, output int n);
    ok = 1'b0; n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rx_clear) begin ok = 1'b1; n = i + 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_clear: got no pulse expected rx_clear within 40 cycles");
    end
  endtask

  // mode: 0 plain, 1 rd_en on push edge, 2 reset between capture and push,
  // 3 ovf_clr on push edge
  task automatic send_byte(input logic [7:0] b, input int d, input int idle,
                           input int mode, output int n);
    bit ok;
    wait_clear(ok, n);
    if (!ok) return;
    rx_word = {1'b0, 7'($urandom), 8'($urandom)};
    repeat (d) @(negedge clk);
    rx_word = 16'h8000;
    repeat (1 + idle) @(negedge clk);
    rx_word = {1'b0, 7'($urandom), b};
    cap_now = 1'b1;
    @(posedge clk); #1;
    cap_now = 1'b0;
    rx_word = 16'h0000;
    case (mode)
      1: rd_dir = 1'b1;
      2: begin
        rst_n = 1'b0; #2; rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_clear", int'(rx_clear), 1);
        chk("rstmid_level", int'(level), 0);
        chk("rstmid_empty", int'(empty), 1);
        return;
      end
      3: ovf_dir = 1'b1;
      default: ;
    endcase
    @(posedge clk); #1;
    if (mode == 1) rd_dir = 1'b0;
    if (mode == 3) ovf_dir = 1'b0;
  endtask

  initial begin
    int n;
    bit ok;
    repeat (2) @(negedge clk);
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_clear", int'(rx_clear), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; mon_en = 1'b1;

    send_byte(8'h41, 1, 0, 0, n);
    chk("first_clear_cycle", n, 1);
    @(negedge clk);
    chk("lat_rd_data", int'(rd_data), 8'h41);
    chk("lat_level", int'(level), 1);
    chk("second_clear", int'(rx_clear), 1);
    @(posedge clk); #1; rd_dir = 1'b1;
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1; rd_dir = 1'b0;
    @(negedge clk);
    chk("pop_empty_level", int'(level), 0);

    for (int i = 0; i < DEPTH; i++) send_byte(8'(i), $urandom_range(1, T), $urandom_range(0, 2), 0, n);
    @(negedge clk);
    chk("fill_full", int'(full), 1);
    chk("fill_level", int'(level), DEPTH);
    send_byte(8'h10, 2, 1, 0, n);
    @(negedge clk);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_level", int'(level), DEPTH);
    chk("ovf_head", int'(rd_data), 8'h00);
    @(posedge clk); #1; ovf_dir = 1'b1;
    @(posedge clk); #1; ovf_dir = 1'b0;
    @(negedge clk);
    chk("ovf_clr", int'(overflow), 0);
    send_byte(8'h12, 1, 0, 3, n);
    @(negedge clk);
    chk("ovf_prio", int'(overflow), 1);
    @(posedge clk); #1; ovf_dir = 1'b1;
    @(posedge clk); #1; ovf_dir = 1'b0;
    send_byte(8'h11, T, 0, 1, n);
    @(negedge clk);
    chk("fullpop_ovf", int'(overflow), 0);
    chk("fullpop_level", int'(level), DEPTH);

    @(posedge clk); #1; rd_dir = 1'b1;
    for (int i = 0; i < 40 && mlevel > 0; i++) @(posedge clk);
    #1; rd_dir = 1'b0;

    wait_clear(ok, n);
    rx_word = 16'h0055;
    for (int i = 1; i <= 3 * (T + 1); i++) begin
      @(negedge clk);
      chk("timeout_clear", int'(rx_clear), int'((i % (T + 1)) == 0));
    end
    rx_word = 16'h0000;

    send_byte(8'h98, 1, 0, 0, n);
    send_byte(8'h99, 1, 0, 2, n);

    cons_en = 1'b1;
    for (int k = 0; k < 160; k++) begin
      rd_pct = (k < 80) ? 8 : 60;
      send_byte(8'($urandom), $urandom_range(1, T), $urandom_range(0, 3), 0, n);
    end
    @(posedge clk); #1;
    cons_en = 1'b0; rd_dir = 1'b1;
    for (int i = 0; i < 40 && mlevel > 0; i++) @(posedge clk);
    #1; rd_dir = 1'b0;
    @(negedge clk);
    chk("end_empty", int'(empty), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
